uart_rx_fifo: RTL

Receive-side byte FIFO placed directly downstream of uart_recv. It captures every one-cycle valid/data byte the receiver produces and buffers it until the consumer (command decoder or display logic) reads it. A registered read port returns each byte with a one-cycle read-valid pulse. Occupancy and full/empty status are exported, and a sticky overflow flag records any byte dropped because the FIFO was full.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between uart_recv/consumer and the receive FIFO.
// The slave modport is the FIFO side and the master modport is the producer/consumer side.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf;

  modport master (
    output wr_valid, wr_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_recv.
// It has a registered read port, occupancy and full/empty status, and a sticky overflow flag for dropped bytes.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, rd_acc, wr_acc, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    rd_acc     = bus.rd_en && !empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept a write.
    wr_acc     = bus.wr_valid && (!full || rd_acc);
    drop       = bus.wr_valid && full && !rd_acc;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)             overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule
